// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared state encoding, opcodes, LFSR taps and reference ALU for the BIST controller
package alu_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Operands arrive zero-extended to 8 bits; the caller keeps the low N bits,
    // so add and sub wrap modulo 2^N with no carry or borrow kept.
    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : a | b;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/alu_bist_ctrl_if.sv
// alu_bist_ctrl_if: controller <-> ALU/host signal bundle; fail_vec exists only with ALU_BIST_STOP_ON_ERR_EN
interface alu_bist_ctrl_if #(
    parameter int N = 4
);
    logic          start;
    logic [N-1:0]  alu_in0;
    logic [N-1:0]  alu_in1;
    logic [N-1:0]  alu_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic [15:0]   vec_count;
`ifdef ALU_BIST_STOP_ON_ERR_EN
    logic [15:0]   fail_vec;
    modport master (
        input  start, alu_out,
        output alu_in0, alu_in1, busy, done, pass, err_count, vec_count, fail_vec
    );
    modport slave (
        output start, alu_out,
        input  alu_in0, alu_in1, busy, done, pass, err_count, vec_count, fail_vec
    );
`else
    modport master (
        input  start, alu_out,
        output alu_in0, alu_in1, busy, done, pass, err_count, vec_count
    );
    modport slave (
        output start, alu_out,
        input  alu_in0, alu_in1, busy, done, pass, err_count, vec_count
    );
`endif
endinterface

// File: rtl/alu_bist_ctrl_lfsr16_galois.sv
// lfsr16_galois: 16-bit Galois LFSR; load with step together produces step(seed) in one edge
module lfsr16_galois
    import alu_bist_pkg::*;
#(
    parameter logic [15:0] RST_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    logic [15:0] base;

    assign base = load ? seed : state;

    // reload from seed and/or advance one step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_VAL;
        else if (load || step) state <= step ? lfsr_step(base) : base;
    end
endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: LFSR-driven self-test initiator for an N-bit ALU; ALU_BIST_STOP_ON_ERR_EN ends a run at the first mismatch
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int          N           = 4,
    parameter logic [1:0]  OPCODE      = OP_ADD,
    parameter int          NUM_VECTORS = 10,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input logic             clk,
    input logic             rst_n,
    alu_bist_ctrl_if.master bus
);
    localparam logic [15:0] LAST = 16'(NUM_VECTORS > 0 ? NUM_VECTORS - 1 : 0);

    state_t       state_q, state_d;
    logic [N-1:0] in0_q, in0_d, in1_q, in1_d, exp_q, exp_d;
    logic         busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]  err_q, err_d, vec_q, vec_d;
    logic [15:0]  lfsr_q, src;
    logic [7:0]   ref8;
    logic [N-1:0] a_n, b_n, exp_n;
    logic [15:0]  err_inc;
    logic         lfsr_ld, lfsr_st, mis, stop;
`ifdef ALU_BIST_STOP_ON_ERR_EN
    logic [15:0]  fail_q, fail_d;
`endif

    lfsr16_galois #(.RST_VAL(SEED)) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (lfsr_ld),
        .step (lfsr_st),
        .seed (SEED),
        .state(lfsr_q)
    );

    // The first vector of a run comes straight from SEED; later ones from the running LFSR.
    assign src     = state_q == RUN ? lfsr_q : SEED;
    assign a_n     = N'(src);
    assign b_n     = N'(src >> N);
    assign ref8    = alu_ref(OPCODE, 8'(a_n), 8'(b_n));
    assign exp_n   = N'(ref8);
    assign mis     = bus.alu_out != exp_q;
    assign err_inc = err_q + 16'(mis && err_q != 16'hFFFF);
`ifdef ALU_BIST_STOP_ON_ERR_EN
    assign stop    = vec_q == LAST || mis;
`else
    assign stop    = vec_q == LAST;
`endif

    // next-state and next-output logic; every output is held unless a transition updates it
    always_comb begin
        state_d = state_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        vec_d   = vec_q;
        lfsr_ld = 1'b0;
        lfsr_st = 1'b0;
`ifdef ALU_BIST_STOP_ON_ERR_EN
        fail_d  = fail_q;
`endif
        if (state_q != RUN && bus.start) begin
            err_d  = 16'h0000;
            vec_d  = 16'h0000;
            pass_d = 1'b0;
`ifdef ALU_BIST_STOP_ON_ERR_EN
            fail_d = 16'h0000;
`endif
            if (NUM_VECTORS == 0) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end else begin
                state_d = RUN;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                in0_d   = a_n;
                in1_d   = b_n;
                exp_d   = exp_n;
                lfsr_ld = 1'b1;
                lfsr_st = 1'b1;
            end
        end else if (state_q == RUN) begin
            err_d = err_inc;
            vec_d = vec_q + 16'd1;
            if (stop) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = err_inc == 16'h0000;
`ifdef ALU_BIST_STOP_ON_ERR_EN
                if (mis) fail_d = vec_q;
`endif
            end else begin
                in0_d   = a_n;
                in1_d   = b_n;
                exp_d   = exp_n;
                lfsr_st = 1'b1;
            end
        end
    end

    // state and registered outputs; reset clears any partial result at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            in0_q   <= '0;
            in1_q   <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 16'h0000;
            vec_q   <= 16'h0000;
`ifdef ALU_BIST_STOP_ON_ERR_EN
            fail_q  <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
`ifdef ALU_BIST_STOP_ON_ERR_EN
            fail_q  <= fail_d;
`endif
        end
    end

    assign bus.alu_in0   = in0_q;
    assign bus.alu_in1   = in1_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.vec_count = vec_q;
`ifdef ALU_BIST_STOP_ON_ERR_EN
    assign bus.fail_vec  = fail_q;
`endif
endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
- Hardware initiator for the opcode-parameterized N-bit ALU.
- Generates pseudo-random operand pairs from a 16-bit LFSR and drives them into the combinational ALU.
- Compares each ALU result against an internal reference model and reports the vector count, error count and pass/fail.
- Sits beside the ALU as an on-chip self-test controller.

Parameters:
- N, 4: operand/result width; legal range 1..8.
- OPCODE, 2'b00: operation checked by the reference model. 00 add, 01 sub, 10 AND, 11 OR.
- NUM_VECTORS, 10: vectors per run; legal range 0..65535.
- SEED, 16'hACE1: LFSR reload value; must be nonzero.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, one-cycle pulse or level.
- alu_in0  out  N  operand A to the ALU.
- alu_in1  out  N  operand B to the ALU.
- alu_out  in  N  ALU result, combinational from alu_in0/alu_in1.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  valid when done=1; 1 means zero mismatches.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- vec_count  out  16  vectors checked this run.

Behaviour:
- Interface (fixed): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, lfsr=SEED, alu_in0=alu_in1=0, expected=0. busy=done=pass=0, err_count=vec_count=0.
- Operand slicing: alu_in0 = lfsr[N-1:0], alu_in1 = lfsr[2N-1:N].
- LFSR: 16-bit Galois, taps 16'hB400. Each step: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Reference model: expected = OPCODE applied to the two slices, truncated to N bits. Add and sub wrap modulo 2^N; no carry or borrow is kept.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE + start, NUM_VECTORS>0:
  - clear counters; load operands and expected from SEED; lfsr <= step(SEED).
  - busy<=1, done<=0; go to RUN.
- IDLE + start, NUM_VECTORS=0: go straight to DONE with pass=1 and counters 0.
- RUN, each cycle:
  - compare alu_out to expected at the clock edge.
  - on mismatch, err_count++ (saturating); vec_count++ always.
  - if this was vector NUM_VECTORS: go to DONE, busy<=0, done<=1, pass <= (final err_count==0).
  - otherwise: load the next operands and expected from lfsr, and step lfsr.
- Throughput and latency: one vector per cycle. done rises NUM_VECTORS+1 edges after the edge that samples start.
- Operands hold their last values in DONE and IDLE.
- start while busy: ignored.
- DONE + start: identical to IDLE + start. Counters clear, LFSR reloads from SEED, so every run is reproducible.
- DONE without start: hold all outputs.
- rst_n low mid-run: immediate return to reset values. No partial result survives.

Optional Feature:
- Macro: ALU_BIST_STOP_ON_ERR_EN.
- Defined:
  - the first mismatch ends the run. vec_count includes the failing vector; err_count=1; DONE with pass=0.
  - an extra output port fail_vec (16 bits) holds the 0-based index of the failing vector. fail_vec resets to 0 and clears on start.
- Undefined: all NUM_VECTORS vectors always run. No fail_vec port exists.

Decomposition:
- Package alu_bist_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR;
  - LFSR_TAPS=16'hB400;
  - function alu_ref(op,a,b).
- Sub-module lfsr16_galois: inputs clk, rst_n, load, step, seed; output state. The controller instantiates it once.

Test Plan:
1. Correct ALU (add), N=4, OPCODE=00, defaults, start pulse:
   - first applied vector is in0=4'h1, in1=4'hE, expected 4'hF;
   - done after 11 edges; vec_count=10, err_count=0, pass=1.
2. Same setup, OPCODE=01 with a matching sub ALU: first expected = 4'h3 (1-14 wraps mod 16); pass=1.
3. Bench forces alu_out[0]=0 (stuck-at-0):
   - err_count equals the number of vectors whose expected bit0=1; err_count>0 and pass=0.
   - with ALU_BIST_STOP_ON_ERR_EN: fail_vec = 0 (first expected 4'hF), vec_count=1.
4. Start asserted continuously during RUN: run is not restarted and vec_count is monotonic. A second start in DONE reproduces a run identical to scenario 1, including the first vector 1/E.
5. rst_n dropped at the 5th RUN cycle:
   - outputs return to reset values immediately, without a clock edge;
   - after release and start, the result equals scenario 1.
6. NUM_VECTORS=0: start gives done=1, pass=1, counts 0, one edge later.
